// File: rtl/datapath_param.sv
// datapath_param: parametrised single-bus datapath (register file, HI/LO,
// Y, Z pair, PC, IR, MAR, MDR, in/out ports) with a start/busy/done ALU.
// Optional build macro DATAPATH_ITER_MULDIV_EN: when defined, MUL/DIV run
// iteratively (shift-add / restoring) for WIDTH cycles; otherwise they
// complete in a single cycle. Both builds produce identical results.
module datapath_param #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int C_BITS = 19
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 src_sel,
    input  logic [$clog2(NREGS)-1:0]   reg_sel,
    input  logic                       reg_in,
    input  logic                       ba_out,
    input  logic                       hi_in,
    input  logic                       lo_in,
    input  logic                       y_in,
    input  logic                       alu_start,
    input  logic [4:0]                 opcode,
    input  logic                       pc_in,
    input  logic                       inc_pc,
    input  logic                       ir_in,
    input  logic                       mar_in,
    input  logic                       mdr_in,
    input  logic                       read,
    input  logic [WIDTH-1:0]           mdata_in,
    input  logic                       inport_in,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       outport_in,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           bus_out,
    output logic [WIDTH-1:0]           ir_out,
    output logic [WIDTH-1:0]           mar_out,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           outport_out
);
    localparam int RSEL = $clog2(NREGS);
    localparam logic [WIDTH-1:0] W_V = WIDTH'(WIDTH);
    localparam logic [4:0] OP_MUL = 5'd9;
    localparam logic [4:0] OP_DIV = 5'd10;

    logic [WIDTH-1:0] reg_file [NREGS];
    logic [WIDTH-1:0] hi_reg, lo_reg, y_reg, z_hi_reg, z_lo_reg;
    logic [WIDTH-1:0] pc_reg, ir_reg, mar_reg, mdr_reg, inport_reg, outport_reg;
    logic [WIDTH-1:0] bus;
    logic             busy_reg, done_reg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef DATAPATH_ITER_MULDIV_EN
        S_RUN  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;
    state_t state_reg;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Apply the operand signs to an unsigned magnitude product.
    function automatic logic [2*WIDTH-1:0] mul_fix(input logic [WIDTH-1:0] a, b,
                                                   input logic [2*WIDTH-1:0] mag);
        return (a[WIDTH-1] ^ b[WIDTH-1]) ? -mag : mag;
    endfunction

    // Quotient truncates toward zero, remainder follows the dividend's sign;
    // divide-by-zero yields {A, all ones}.
    function automatic logic [2*WIDTH-1:0] div_fix(input logic [WIDTH-1:0] a, b, q, r);
        logic [WIDTH-1:0] qs, rs;
        if (b == '0)
            return {a, {WIDTH{1'b1}}};
        qs = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q : q;
        rs = a[WIDTH-1] ? -r : r;
        return {rs, qs};
    endfunction

    function automatic logic [2*WIDTH-1:0] alu_single(input logic [4:0] op,
                                                      input logic [WIDTH-1:0] a, b);
        logic [WIDTH-1:0] amt, res;
        amt = b % W_V;
        res = '0;
        case (op)
            5'd0:  res = a + b;
            5'd1:  res = a - b;
            5'd2:  res = a & b;
            5'd3:  res = a | b;
            5'd4:  res = a >> amt;
            5'd5:  res = $signed(a) >>> amt;
            5'd6:  res = a << amt;
            5'd7:  res = (a >> amt) | (a << (W_V - amt));
            5'd8:  res = (a << amt) | (a >> (W_V - amt));
`ifndef DATAPATH_ITER_MULDIV_EN
            5'd9:  return mul_fix(a, b, {{WIDTH{1'b0}}, abs_w(a)} * {{WIDTH{1'b0}}, abs_w(b)});
            5'd10: return div_fix(a, b, abs_w(a) / abs_w(b), abs_w(a) % abs_w(b));
`endif
            5'd11: res = -b;
            5'd12: res = ~b;
            default: res = '0;
        endcase
        return {{WIDTH{1'b0}}, res};
    endfunction

    // Bus source multiplexer; C is the sign-extended IR immediate.
    always_comb begin
        bus = '0;
        case (src_sel)
            4'd0: bus = (ba_out && reg_sel == '0) ? '0 : reg_file[reg_sel];
            4'd1: bus = hi_reg;
            4'd2: bus = lo_reg;
            4'd3: bus = z_hi_reg;
            4'd4: bus = z_lo_reg;
            4'd5: bus = pc_reg;
            4'd6: bus = mdr_reg;
            4'd7: bus = inport_reg;
            4'd8: bus = {{(WIDTH-C_BITS){ir_reg[C_BITS-1]}}, ir_reg[C_BITS-1:0]};
            default: bus = '0;
        endcase
    end

    // One register per general-purpose slot, written from the bus when selected.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            logic [WIDTH-1:0] r_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    r_reg <= '0;
                else if (reg_in && reg_sel == RSEL'(gi))
                    r_reg <= bus;
            end
            assign reg_file[gi] = r_reg;
        end
    endgenerate

    // Special-purpose registers and I/O ports.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_reg <= '0;  lo_reg <= '0;  y_reg <= '0;
            pc_reg <= '0;  ir_reg <= '0;  mar_reg <= '0;  mdr_reg <= '0;
            inport_reg <= '0;  outport_reg <= '0;
        end else begin
            if (hi_in)      hi_reg      <= bus;
            if (lo_in)      lo_reg      <= bus;
            if (y_in)       y_reg       <= bus;
            if (ir_in)      ir_reg      <= bus;
            if (mar_in)     mar_reg     <= bus;
            if (mdr_in)     mdr_reg     <= read ? mdata_in : bus;
            if (inport_in)  inport_reg  <= in_data;
            if (outport_in) outport_reg <= bus;
            if (pc_in)       pc_reg <= bus;
            else if (inc_pc) pc_reg <= pc_reg + 1'b1;
        end
    end

`ifdef DATAPATH_ITER_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH);
    logic [WIDTH-1:0]   a_reg, b_reg, w_hi_reg, w_lo_reg, w_hi_next, w_lo_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_mul_reg;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] iter_result;

    // One shift-add (MUL) or restoring-subtract (DIV) step on magnitudes.
    always_comb begin
        mul_sum  = {1'b0, w_hi_reg} + (w_lo_reg[0] ? {1'b0, abs_w(a_reg)} : '0);
        div_diff = {w_hi_reg, w_lo_reg[WIDTH-1]} - {1'b0, abs_w(b_reg)};
        if (is_mul_reg) begin
            w_hi_next = mul_sum[WIDTH:1];
            w_lo_next = {mul_sum[0], w_lo_reg[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            w_hi_next = div_diff[WIDTH-1:0];
            w_lo_next = {w_lo_reg[WIDTH-2:0], 1'b1};
        end else begin
            w_hi_next = {w_hi_reg[WIDTH-2:0], w_lo_reg[WIDTH-1]};
            w_lo_next = {w_lo_reg[WIDTH-2:0], 1'b0};
        end
        iter_result = is_mul_reg ? mul_fix(a_reg, b_reg, {w_hi_next, w_lo_next})
                                 : div_fix(a_reg, b_reg, w_lo_next, w_hi_next);
    end
`endif

    // ALU control FSM: accepts starts in IDLE/DONE, writes Z, pulses done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            z_hi_reg  <= '0;
            z_lo_reg  <= '0;
`ifdef DATAPATH_ITER_MULDIV_EN
            a_reg <= '0;  b_reg <= '0;  w_hi_reg <= '0;  w_lo_reg <= '0;
            cnt_reg <= '0;  is_mul_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
`ifdef DATAPATH_ITER_MULDIV_EN
                S_RUN: begin
                    w_hi_reg <= w_hi_next;
                    w_lo_reg <= w_lo_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH-1)) begin
                        {z_hi_reg, z_lo_reg} <= iter_result;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
`endif
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                    if (alu_start) begin
`ifdef DATAPATH_ITER_MULDIV_EN
                        if (opcode == OP_MUL || opcode == OP_DIV) begin
                            a_reg      <= y_reg;
                            b_reg      <= bus;
                            is_mul_reg <= (opcode == OP_MUL);
                            w_hi_reg   <= '0;
                            w_lo_reg   <= (opcode == OP_MUL) ? abs_w(bus) : abs_w(y_reg);
                            cnt_reg    <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= S_RUN;
                        end else
`endif
                        begin
                            {z_hi_reg, z_lo_reg} <= alu_single(opcode, y_reg, bus);
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus_out     = bus;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ir_out      = ir_reg;
    assign mar_out     = mar_reg;
    assign pc_out      = pc_reg;
    assign outport_out = outport_reg;
endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: randomized self-checking bench for datapath_param,
// compared against an arithmetic reference model of the ALU and registers.
module tb_datapath_param;
    localparam int WIDTH = 32;
    localparam int NREGS = 16;
`ifdef DATAPATH_ITER_MULDIV_EN
    localparam bit ITER = 1'b1;
`else
    localparam bit ITER = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b0;
    logic [3:0]  src_sel = '0;
    logic [3:0]  reg_sel = '0;
    logic        reg_in = 0, ba_out = 0, hi_in = 0, lo_in = 0, y_in = 0, alu_start = 0;
    logic [4:0]  opcode = '0;
    logic        pc_in = 0, inc_pc = 0, ir_in = 0, mar_in = 0, mdr_in = 0, read = 0;
    logic [31:0] mdata_in = '0, in_data = '0;
    logic        inport_in = 0, outport_in = 0;
    logic        busy, done;
    logic [31:0] bus_out, ir_out, mar_out, pc_out, outport_out;

    int errors = 0;
    int checks = 0;

    datapath_param #(.WIDTH(WIDTH), .NREGS(NREGS), .C_BITS(19)) dut (
        .clock(clock), .reset(reset), .src_sel(src_sel), .reg_sel(reg_sel),
        .reg_in(reg_in), .ba_out(ba_out), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in),
        .alu_start(alu_start), .opcode(opcode), .pc_in(pc_in), .inc_pc(inc_pc),
        .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .read(read),
        .mdata_in(mdata_in), .inport_in(inport_in), .in_data(in_data),
        .outport_in(outport_in), .busy(busy), .done(done), .bus_out(bus_out),
        .ir_out(ir_out), .mar_out(mar_out), .pc_out(pc_out), .outport_out(outport_out)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference ALU: {ZHI, ZLO} computed with 64-bit signed arithmetic.
    function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        int sh;
        logic [63:0] aa;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        aa = {a, a};
        case (op)
            0:  return {32'h0, a + b};
            1:  return {32'h0, a - b};
            2:  return {32'h0, a & b};
            3:  return {32'h0, a | b};
            4:  return {32'h0, a >> sh};
            5:  begin p = sa >>> sh; return {32'h0, p[31:0]}; end
            6:  return {32'h0, a << sh};
            7:  begin aa = aa >> sh; return {32'h0, aa[31:0]}; end
            8:  begin aa = aa << sh; return {32'h0, aa[63:32]}; end
            9:  begin p = sa * sb; return p; end
            10: begin
                    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                    q = sa / sb;
                    r = sa - q * sb;
                    return {r[31:0], q[31:0]};
                end
            11: return {32'h0, 32'h0 - b};
            12: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put_inport(input logic [31:0] v);
        in_data = v; inport_in = 1; step(); inport_in = 0;
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
        put_inport(v);
        src_sel = 4'd7; reg_sel = idx; reg_in = 1; step(); reg_in = 0;
    endtask

    task automatic set_y(input logic [31:0] v);
        put_inport(v);
        src_sel = 4'd7; y_in = 1; step(); y_in = 0;
    endtask

    // Runs one ALU op (A=Y=a, B=bus=b); reports Z, done latency, busy cycles.
    task automatic run_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] zhi, output logic [31:0] zlo,
                           output int lat, output int busy_cnt, output logic done_after);
        set_y(a);
        put_inport(b);
        src_sel = 4'd7; opcode = 5'(op); alu_start = 1; step(); alu_start = 0;
        lat = 0; busy_cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) busy_cnt++;
            if (done) begin lat = c; break; end
            step();
        end
        src_sel = 4'd3; #1 zhi = bus_out;
        src_sel = 4'd4; #1 zlo = bus_out;
        step();
        done_after = done;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if ({ir_out, mar_out, pc_out, outport_out} !== 128'h0) begin
            errors++; $display("FAIL reset_regs: ir=%h mar=%h pc=%h out=%h, required all 0", ir_out, mar_out, pc_out, outport_out);
        end
        for (int s = 0; s < 16; s++) begin
            src_sel = 4'(s); #1;
            checks++;
            if (bus_out !== 32'h0) begin
                errors++; $display("FAIL reset_bus src=%0d: got %h, required 0", s, bus_out);
            end
        end
        // async clear mid-cycle
        put_inport(32'h1234_5678);
        src_sel = 4'd7; pc_in = 1; step(); pc_in = 0;
        #2 reset = 0; #1;
        checks++;
        if (pc_out !== 32'h0) begin
            errors++; $display("FAIL reset_async_pc: got %h, required 0", pc_out);
        end
        #2 reset = 1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_regs();
        logic [31:0] model [16];
        load_reg(4'd3, 32'h0000_00A5);
        src_sel = 4'd0; reg_sel = 4'd3; #1;
        checks++;
        if (bus_out !== 32'h0000_00A5) begin
            errors++; $display("FAIL reg3_a5: got %h, required 000000a5", bus_out);
        end
        load_reg(4'd0, 32'h0000_1234);
        src_sel = 4'd0; reg_sel = 4'd0; ba_out = 1; #1;
        checks++;
        if (bus_out !== 32'h0) begin
            errors++; $display("FAIL ba_out_r0: got %h, required 0", bus_out);
        end
        ba_out = 0; #1;
        checks++;
        if (bus_out !== 32'h0000_1234) begin
            errors++; $display("FAIL r0_read: got %h, required 00001234", bus_out);
        end
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            load_reg(4'(i), model[i]);
        end
        for (int i = 0; i < 16; i++) begin
            src_sel = 4'd0; reg_sel = 4'(i); ba_out = (i % 2 == 1); #1;
            checks++;
            if (bus_out !== model[i]) begin
                errors++; $display("FAIL reg_read r%0d: got %h, required %h", i, bus_out, model[i]);
            end
        end
        ba_out = 0;
        // same-cycle read and write of one register carries the old value
        put_inport(32'hCAFE_0001);
        src_sel = 4'd0; reg_sel = 4'd5; reg_in = 1; #1;
        checks++;
        if (bus_out !== model[5]) begin
            errors++; $display("FAIL same_cycle_rw: got %h, required %h", bus_out, model[5]);
        end
        step(); reg_in = 0;
        $display("test_regs done");
    endtask

    task automatic test_special_regs();
        logic [31:0] v_hi, v_lo, v_mar, v_out, v_mdr, v_mem;
        v_hi = $urandom; v_lo = $urandom; v_mar = $urandom; v_out = $urandom; v_mdr = $urandom; v_mem = $urandom;
        put_inport(v_hi);  src_sel = 4'd7; hi_in = 1;      step(); hi_in = 0;
        put_inport(v_lo);  src_sel = 4'd7; lo_in = 1;      step(); lo_in = 0;
        put_inport(v_mar); src_sel = 4'd7; mar_in = 1;     step(); mar_in = 0;
        put_inport(v_out); src_sel = 4'd7; outport_in = 1; step(); outport_in = 0;
        put_inport(v_mdr); src_sel = 4'd7; mdr_in = 1; read = 0; step(); mdr_in = 0;
        src_sel = 4'd1; #1; checks++;
        if (bus_out !== v_hi) begin errors++; $display("FAIL hi_load: got %h, required %h", bus_out, v_hi); end
        src_sel = 4'd2; #1; checks++;
        if (bus_out !== v_lo) begin errors++; $display("FAIL lo_load: got %h, required %h", bus_out, v_lo); end
        checks++;
        if (mar_out !== v_mar) begin errors++; $display("FAIL mar_load: got %h, required %h", mar_out, v_mar); end
        checks++;
        if (outport_out !== v_out) begin errors++; $display("FAIL outport_load: got %h, required %h", outport_out, v_out); end
        src_sel = 4'd6; #1; checks++;
        if (bus_out !== v_mdr) begin errors++; $display("FAIL mdr_from_bus: got %h, required %h", bus_out, v_mdr); end
        mdata_in = v_mem; read = 1; mdr_in = 1; step(); mdr_in = 0; read = 0;
        src_sel = 4'd6; #1; checks++;
        if (bus_out !== v_mem) begin errors++; $display("FAIL mdr_from_mem: got %h, required %h", bus_out, v_mem); end
        $display("test_special_regs done");
    endtask

    task automatic test_pc_ir();
        logic [31:0] v;
        logic [31:0] ex;
        put_inport(32'hFFFF_FFFF); src_sel = 4'd7; pc_in = 1; step(); pc_in = 0;
        inc_pc = 1; step(); inc_pc = 0;
        checks++;
        if (pc_out !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h, required 0", pc_out); end
        inc_pc = 1; step(); step(); step(); inc_pc = 0;
        checks++;
        if (pc_out !== 32'd3) begin errors++; $display("FAIL pc_inc3: got %h, required 3", pc_out); end
        put_inport(32'h40); src_sel = 4'd7; pc_in = 1; inc_pc = 1; step(); pc_in = 0; inc_pc = 0;
        checks++;
        if (pc_out !== 32'h40) begin errors++; $display("FAIL pc_priority: got %h, required 40", pc_out); end
        put_inport(32'h0004_0000); src_sel = 4'd7; ir_in = 1; step(); ir_in = 0;
        src_sel = 4'd8; #1; checks++;
        if (bus_out !== 32'hFFFC_0000) begin errors++; $display("FAIL c_sext_neg: got %h, required fffc0000", bus_out); end
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            put_inport(v); src_sel = 4'd7; ir_in = 1; step(); ir_in = 0;
            ex = (v % 32'h8_0000) - (v[18] ? 32'h8_0000 : 32'h0);
            checks++;
            if (ir_out !== v) begin errors++; $display("FAIL ir_load: got %h, required %h", ir_out, v); end
            src_sel = 4'd8; #1; checks++;
            if (bus_out !== ex) begin errors++; $display("FAIL c_sext: ir=%h got %h, required %h", v, bus_out, ex); end
        end
        $display("test_pc_ir done");
    endtask

    task automatic check_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] zhi, zlo;
        logic [63:0] ex;
        int lat, bc, ex_lat, ex_bc;
        logic da;
        bit md;
        md = (op == 9 || op == 10);
        ex = ref_alu(op, a, b);
        ex_lat = (ITER && md) ? WIDTH + 1 : 1;
        ex_bc  = (ITER && md) ? WIDTH : 0;
        run_alu(op, a, b, zhi, zlo, lat, bc, da);
        $display("alu op=%0d a=%h b=%h -> zhi=%h zlo=%h lat=%0d", op, a, b, zhi, zlo, lat);
        checks++;
        if ({zhi, zlo} !== ex) begin
            errors++; $display("FAIL alu_z op=%0d a=%h b=%h: got %h_%h, required %h_%h", op, a, b, zhi, zlo, ex[63:32], ex[31:0]);
        end
        checks++;
        if (lat !== ex_lat) begin errors++; $display("FAIL alu_latency op=%0d: got %0d, required %0d", op, lat, ex_lat); end
        checks++;
        if (bc !== ex_bc) begin errors++; $display("FAIL alu_busy_cycles op=%0d: got %0d, required %0d", op, bc, ex_bc); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL alu_done_pulse op=%0d: done still %b, required 0", op, da); end
    endtask

    task automatic test_alu_single();
        int op;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 31);
            if (op == 9 || op == 10) op = i % 13 == 9 ? 12 : i % 9;
            b = (i % 2 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            check_op(op, $urandom, b);
        end
        $display("test_alu_single done");
    endtask

    task automatic test_muldiv();
        logic [31:0] a, b;
        check_op(9, 32'd7, 32'hFFFF_FFFD);
        check_op(10, 32'hFFFF_FFF9, 32'd2);
        check_op(10, 32'd9, 32'd0);
        check_op(10, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op(9, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 500)) - 32'd250 : $urandom;
            check_op(9 + (i % 2), a, b);
        end
        $display("test_muldiv done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] z0, z;
        logic [63:0] ex;
        int lat;
        // record the current ZLO, then start MUL(7, -3)
        src_sel = 4'd4; #1 z0 = bus_out;
        set_y(32'd7); put_inport(32'hFFFF_FFFD);
        src_sel = 4'd7; opcode = 5'd9; alu_start = 1; step(); alu_start = 0;
`ifdef DATAPATH_ITER_MULDIV_EN
        step(); step();
        opcode = 5'd0; alu_start = 1; step(); alu_start = 0;
        src_sel = 4'd4; #1;
        checks++;
        if (busy !== 1'b1 || bus_out !== z0) begin
            errors++; $display("FAIL start_while_busy: busy=%b zlo=%h, required 1 %h", busy, bus_out, z0);
        end
        lat = 4;
        while (!done && lat < 200) begin step(); lat++; end
        checks++;
        if (lat !== WIDTH + 1) begin errors++; $display("FAIL busy_ignore_latency: got %0d, required %0d", lat, WIDTH + 1); end
`else
        // a second start in the DONE cycle is accepted like IDLE
        lat = 1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL first_done: got %b, required 1", done); end
        src_sel = 4'd7; opcode = 5'd0; alu_start = 1; step(); alu_start = 0;
        z0 = 32'hFFFF_FFFD + 32'd7;
`endif
        src_sel = 4'd4; #1 z = bus_out;
        ex = ITER ? ref_alu(9, 32'd7, 32'hFFFF_FFFD) : {32'h0, z0};
        $display("back_to_back zlo=%h lat=%0d", z, lat);
        checks++;
        if (z !== ex[31:0]) begin errors++; $display("FAIL back_to_back_z: got %h, required %h", z, ex[31:0]); end
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_mid_reset();
        int seen;
        set_y(32'd7); put_inport(32'hFFFF_FFFD);
        src_sel = 4'd7; opcode = 5'd9; alu_start = 1; step(); alu_start = 0;
        for (int i = 0; i < 9; i++) step();
        reset = 0; #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: busy=%b done=%b, required 0 0", busy, done);
        end
        src_sel = 4'd3; #1; checks++;
        if (bus_out !== 32'h0) begin errors++; $display("FAIL mid_reset_zhi: got %h, required 0", bus_out); end
        src_sel = 4'd4; #1; checks++;
        if (bus_out !== 32'h0) begin errors++; $display("FAIL mid_reset_zlo: got %h, required 0", bus_out); end
        reset = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin step(); if (done) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_done: done seen %0d times, required 0", seen); end
        $display("test_mid_reset done");
    endtask

    initial begin
        reset = 0;
        step(); step();
        #2 reset = 1;
        step();
        test_reset();
        test_regs();
        test_special_regs();
        test_pc_ir();
        test_alu_single();
        test_muldiv();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
